// File: rtl/image_frame_collector.sv
// rtl/image_frame_collector.sv - captures a raster pixel stream into a frame buffer and replays it over valid/ready
// Readout uses a one-cycle synchronous RAM read feeding a 2-entry output/skid buffer so a held ready never sees a bubble.
module image_frame_collector #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:PIX_W-1] pix_in,
  input  logic             pix_en,
  output logic [0:PIX_W-1] out_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy,
  output logic             overflow_err
);
  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
  state_t r_state, w_next_state;

  logic [0:PIX_W-1] r_mem [TOTAL];
  logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt;
  logic             r_rd_all;
  logic [0:PIX_W-1] r_rd_data;
  logic             r_rd_valid, r_rd_last;
  logic [0:PIX_W-1] r_out_pix, r_skid_pix;
  logic             r_out_valid, r_out_last, r_skid_valid, r_skid_last;
  logic             r_frame_done, r_overflow;

  logic             w_wr_en, w_wr_last, w_readout, w_pop, w_final, w_issue;
  logic [CNT_W-1:0] w_wr_addr;
  logic [1:0]       w_fill;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_wr_last) w_next_state = READOUT;
               else if (pix_en) w_next_state = CAPTURE;
      CAPTURE: if (w_wr_last) w_next_state = READOUT;
      READOUT: if (w_final) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != IDLE);
    w_readout = (r_state == READOUT);
    w_wr_en   = pix_en && !w_readout;
    w_wr_addr = (r_state == IDLE) ? '0 : r_wr_cnt;
    w_wr_last = w_wr_en && (w_wr_addr == LAST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       r_wr_cnt <= '0;
    else if (w_wr_en) r_wr_cnt <= w_wr_last ? '0 : w_wr_addr + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_wr_en) r_mem[w_wr_addr] <= pix_in;
  end

  // Credit check: never let out + skid + in-flight read exceed the two buffer slots.
  assign w_pop   = r_out_valid && out_ready;
  assign w_final = w_pop && r_out_last;
  assign w_fill  = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_rd_valid) - 2'(w_pop);
  assign w_issue = w_readout && !r_rd_all && (w_fill < 2'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_cnt   <= '0;
      r_rd_all   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= w_issue;
      if (w_issue) r_rd_last <= (r_rd_cnt == LAST_ADDR);
      if (!w_readout) begin
        r_rd_cnt <= '0;
        r_rd_all <= 1'b0;
      end else if (w_issue) begin
        r_rd_all <= (r_rd_cnt == LAST_ADDR);
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) r_rd_data <= r_mem[r_rd_cnt];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_pix    <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_pix   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out_pix    <= r_skid_pix;
        r_out_last   <= r_skid_last;
        r_out_valid  <= 1'b1;
        r_skid_valid <= r_rd_valid;
        r_skid_pix   <= r_rd_data;
        r_skid_last  <= r_rd_last;
      end else begin
        r_out_valid <= r_rd_valid;
        if (r_rd_valid) begin
          r_out_pix  <= r_rd_data;
          r_out_last <= r_rd_last;
        end else begin
          r_out_last <= 1'b0;
        end
      end
    end else if (r_rd_valid) begin
      r_skid_pix   <= r_rd_data;
      r_skid_last  <= r_rd_last;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_final;
      if (pix_en && w_readout) r_overflow <= 1'b1;
    end
  end

  assign out_pix      = r_out_pix;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign frame_done   = r_frame_done;
  assign overflow_err = r_overflow;
endmodule

// File: tb/tb_image_frame_collector.sv
// tb/tb_image_frame_collector.sv - bench for image_frame_collector
// A 4x2 instance runs a cycle-exact vector table; a 32x16 instance runs whole-frame sequences.
module tb_image_frame_collector;
  localparam int BW = 32;
  localparam int BH = 16;
  localparam int BT = BW * BH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst_n, a_en, a_rdy, a_val, a_last, a_fd, a_busy, a_ovf;
  logic [0:7] a_pix, a_opix;
  logic       b_rst_n, b_en, b_rdy, b_val, b_last, b_fd, b_busy, b_ovf;
  logic [0:7] b_pix, b_opix;

  image_frame_collector #(.IMG_W(4), .IMG_H(2), .PIX_W(8)) u_small (
    .clk(clk), .rst_n(a_rst_n), .pix_in(a_pix), .pix_en(a_en),
    .out_pix(a_opix), .out_valid(a_val), .out_ready(a_rdy), .out_last(a_last),
    .frame_done(a_fd), .busy(a_busy), .overflow_err(a_ovf)
  );

  image_frame_collector #(.IMG_W(BW), .IMG_H(BH), .PIX_W(8)) u_big (
    .clk(clk), .rst_n(b_rst_n), .pix_in(b_pix), .pix_en(b_en),
    .out_pix(b_opix), .out_valid(b_val), .out_ready(b_rdy), .out_last(b_last),
    .frame_done(b_fd), .busy(b_busy), .overflow_err(b_ovf)
  );

  typedef struct {
    logic       rst_n, en;
    logic [7:0] pix;
    logic       rdy, val;
    logic [7:0] opix;
    logic       cp, last, fd, busy, ovf;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] p, input logic rd,
                              input logic v, input logic [7:0] op, input logic cp,
                              input logic l, input logic f, input logic b, input logic o);
    vec_t t;
    t.rst_n = r; t.en = e; t.pix = p; t.rdy = rd; t.val = v; t.opix = op;
    t.cp = cp; t.last = l; t.fd = f; t.busy = b; t.ovf = o;
    return t;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bexp(input int i, input bit cm, input logic [7:0] cv);
    return cm ? cv : 8'((i / BW) + (i % BW));
  endfunction

  task automatic cap_frame(input bit cm, input logic [7:0] cv, input bit gaps, input int abort_at);
    for (int i = 0; i < BT; i++) begin
      if (i == abort_at) begin
        b_rst_n = 1'b0; b_en = 1'b1; b_pix = 8'hFF;
        @(posedge clk); #1;
        chk1("abort_busy", b_busy, 1'b0);
        chk1("abort_valid", b_val, 1'b0);
        chk8("abort_pix", b_opix, 8'h00);
        chk1("abort_ovf", b_ovf, 1'b0);
        chk1("abort_fd", b_fd, 1'b0);
        b_rst_n = 1'b1; b_en = 1'b0;
        return;
      end
      b_en = 1'b1;
      b_pix = bexp(i, cm, cv);
      @(posedge clk); #1;
      b_en = 1'b0;
      chk1("cap_busy", b_busy, 1'b1);
      chk1("cap_valid_low", b_val, 1'b0);
      if (gaps) begin
        @(posedge clk); #1;
        chk1("gap_busy", b_busy, 1'b1);
      end
    end
  endtask

  task automatic read_frame(input bit cm, input logic [7:0] cv, input int stall_pct,
                            input bit pulses, input bit lat);
    int got = 0;
    int cyc = 0;
    logic wv, wl, xfer;
    logic [7:0] wp;
    chk1("rd_ovf_clear", b_ovf, 1'b0);
    if (lat) begin
      chk1("lat_n0", b_val, 1'b0);
      @(posedge clk); #1;
      chk1("lat_n1", b_val, 1'b0);
      @(posedge clk); #1;
      chk1("lat_n2", b_val, 1'b1);
      chk8("lat_pix0", b_opix, bexp(0, cm, cv));
    end
    while (got < BT && cyc < BT * 4 + 50) begin
      b_rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99, 0) >= stall_pct);
      b_en = pulses && (cyc == 5 || cyc == 9 || cyc == 13);
      if (b_en) b_pix = 8'hEE;
      wv = b_val; wp = b_opix; wl = b_last;
      xfer = b_val && b_rdy;
      @(posedge clk); #1;
      b_en = 1'b0;
      if (xfer) begin
        chk8("rd_pix", wp, bexp(got, cm, cv));
        chk1("rd_last", wl, got == BT - 1);
        got++;
        if (got == BT) begin
          chk1("fd_high", b_fd, 1'b1);
          chk1("fd_valid_low", b_val, 1'b0);
          chk1("fd_busy_low", b_busy, 1'b0);
        end
      end else if (wv) begin
        chk1("stall_valid", b_val, 1'b1);
        chk8("stall_pix", b_opix, wp);
        chk1("stall_last", b_last, wl);
      end
      if (got > 0 && got < BT) chk1("fd_early", b_fd, 1'b0);
      if (stall_pct == 0 && got > 0 && got < BT) chk1("no_bubble", b_val, 1'b1);
      if (pulses && cyc == 5) chk1("ovf_set", b_ovf, 1'b1);
      cyc++;
    end
    chki("rd_count", got, BT);
    b_rdy = 1'b0;
    @(posedge clk); #1;
    chk1("fd_single", b_fd, 1'b0);
    chk1("ovf_end", b_ovf, pulses);
  endtask

  initial begin
    vec_t tv[$];
    int got;

    a_rst_n = 1'b0; a_en = 1'b0; a_pix = 8'h00; a_rdy = 1'b0;
    b_rst_n = 1'b0; b_en = 1'b0; b_pix = 8'h00; b_rdy = 1'b0;

    // rst, en, pix, rdy | val, opix, chk_pix, last, fd, busy, ovf
    tv.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 8; i++)
      tv.push_back(mk(1'b1, 1'b1, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tv.push_back(mk(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    foreach (tv[k]) begin
      a_rst_n = tv[k].rst_n; a_en = tv[k].en; a_pix = tv[k].pix; a_rdy = tv[k].rdy;
      @(posedge clk); #1;
      chk1($sformatf("v%0d_valid", k), a_val, tv[k].val);
      chk1($sformatf("v%0d_last", k), a_last, tv[k].last);
      chk1($sformatf("v%0d_fd", k), a_fd, tv[k].fd);
      chk1($sformatf("v%0d_busy", k), a_busy, tv[k].busy);
      chk1($sformatf("v%0d_ovf", k), a_ovf, tv[k].ovf);
      if (tv[k].cp) chk8($sformatf("v%0d_pix", k), a_opix, tv[k].opix);
    end

    // Second small frame, started the cycle after frame_done.
    for (int i = 1; i < 8; i++) begin
      a_en = 1'b1; a_pix = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    a_en = 1'b0; a_rdy = 1'b1; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (a_val) begin
        chk8("s2_pix", a_opix, 8'(8'h10 + got));
        chk1("s2_last", a_last, got == 7);
        got++;
      end
      @(posedge clk); #1;
      if (got == 8) begin
        chk1("s2_fd", a_fd, 1'b1);
        chk1("s2_valid_drop", a_val, 1'b0);
      end
    end
    chki("s2_count", got, 8);
    chk1("s2_ovf_sticky", a_ovf, 1'b1);
    @(posedge clk); #1;
    chk1("s2_fd_pulse", a_fd, 1'b0);

    a_rst_n = 1'b0; a_en = 1'b1; a_pix = 8'h55;
    @(posedge clk); #1;
    chk1("rstprio_busy", a_busy, 1'b0);
    chk1("rstprio_ovf", a_ovf, 1'b0);
    chk1("rstprio_valid", a_val, 1'b0);
    a_rst_n = 1'b1; a_en = 1'b0;

    chk1("big_rst_valid", b_val, 1'b0);
    chk1("big_rst_busy", b_busy, 1'b0);
    chk1("big_rst_ovf", b_ovf, 1'b0);
    chk1("big_rst_fd", b_fd, 1'b0);
    chk1("big_rst_last", b_last, 1'b0);
    chk8("big_rst_pix", b_opix, 8'h00);
    b_rst_n = 1'b1;
    @(posedge clk); #1;

    cap_frame(1'b0, 8'h00, 1'b0, -1);
    read_frame(1'b0, 8'h00, 0, 1'b0, 1'b1);
    cap_frame(1'b0, 8'h00, 1'b1, -1);
    read_frame(1'b0, 8'h00, 30, 1'b0, 1'b0);
    cap_frame(1'b0, 8'h00, 1'b0, -1);
    read_frame(1'b0, 8'h00, 0, 1'b1, 1'b0);
    cap_frame(1'b0, 8'h00, 1'b0, 100);
    cap_frame(1'b1, 8'hA5, 1'b0, -1);
    read_frame(1'b1, 8'hA5, 30, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
